// File: rtl/freelist_pkg.sv
// Shared constants and types for the physical-register free list.
// Tag, index and pointer widths all derive from the register counts.
package freelist_pkg;

  localparam int PREG_NUM = 64;
  localparam int LREG_NUM = 32;
  localparam int FL_DEPTH = PREG_NUM - LREG_NUM;

  localparam int PREG_W = $clog2(PREG_NUM);
  localparam int IDX_W  = $clog2(FL_DEPTH);
  // The extra top bit is the wrap bit: equal index with differing wrap means full.
  localparam int PTR_W  = IDX_W + 1;
  localparam int CNT_W  = IDX_W + 1;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [IDX_W-1:0]  idx_t;

endpackage

// File: rtl/freelist.sv
// Circular free list of physical register tags. Rename pops at the speculative head,
// commit pushes released tags at the tail, and a flush rewinds to the architectural head.
module freelist
  import freelist_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              instr0_freelist_req,
  output logic [PREG_W-1:0] instr0_freelist_resp,
  input  logic              instr1_freelist_req,
  output logic [PREG_W-1:0] instr1_freelist_resp,
  output logic              freelist_ready,
  output logic [CNT_W-1:0]  freelist_count,
  input  logic              commit0_free_valid,
  input  logic [PREG_W-1:0] commit0_free_preg,
  input  logic              commit1_free_valid,
  input  logic [PREG_W-1:0] commit1_free_preg,
  input  logic              commit0_alloc_valid,
  input  logic              commit1_alloc_valid,
  input  logic              flush_valid
);

  preg_t fl_mem_q [FL_DEPTH];
  preg_t fl_mem_d [FL_DEPTH];
  ptr_t  spec_head_q, spec_head_d;
  ptr_t  arch_head_q, arch_head_d;
  ptr_t  tail_q, tail_d;

  logic [1:0] n_pop, n_free, n_commit;
  ptr_t       spec_head_p1, tail_p1;

  function automatic ptr_t ptr_add(input ptr_t p, input logic [1:0] n);
    return p + ptr_t'(n);
  endfunction

  function automatic idx_t ptr_idx(input ptr_t p);
    return p[IDX_W-1:0];
  endfunction

  assign n_pop    = {1'b0, instr0_freelist_req} + {1'b0, instr1_freelist_req};
  assign n_free   = {1'b0, commit0_free_valid}  + {1'b0, commit1_free_valid};
  assign n_commit = {1'b0, commit0_alloc_valid} + {1'b0, commit1_alloc_valid};

  assign spec_head_p1 = ptr_add(spec_head_q, 2'd1);
  assign tail_p1      = ptr_add(tail_q, 2'd1);

  // Slot 1 takes the next tag only when slot 0 is also consuming one.
  assign instr0_freelist_resp = fl_mem_q[ptr_idx(spec_head_q)];
  assign instr1_freelist_resp = instr0_freelist_req ? fl_mem_q[ptr_idx(spec_head_p1)]
                                                    : fl_mem_q[ptr_idx(spec_head_q)];

  assign freelist_count = tail_q - spec_head_q;
  assign freelist_ready = (freelist_count >= CNT_W'(2));

  always_comb begin
    arch_head_d = ptr_add(arch_head_q, n_commit);
    tail_d      = ptr_add(tail_q, n_free);
    // Flush target includes this cycle's commits; pops in the flush cycle are dropped.
    spec_head_d = flush_valid ? arch_head_d : ptr_add(spec_head_q, n_pop);

    fl_mem_d = fl_mem_q;
    if (commit0_free_valid)
      fl_mem_d[ptr_idx(tail_q)] = commit0_free_preg;
    if (commit1_free_valid)
      fl_mem_d[ptr_idx(commit0_free_valid ? tail_p1 : tail_q)] = commit1_free_preg;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FL_DEPTH; i++)
        fl_mem_q[i] <= preg_t'(LREG_NUM + i);
      spec_head_q <= '0;
      arch_head_q <= '0;
      tail_q      <= ptr_t'(FL_DEPTH);
    end else begin
      fl_mem_q    <= fl_mem_d;
      spec_head_q <= spec_head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
    end
  end

endmodule
